// File: rtl/tsm_pkg.sv
// Sizing helpers shared by the threshold-masked AND pipeline: share count,
// randomness widths and per-stage randomness offsets.
package tsm_pkg;

    function automatic int share_cnt(input int order);
        return order + 1;
    endfunction

    function automatic int rand_w(input int order, input int width);
        return 3 * width * order * (order + 1) / 2;
    endfunction

    function automatic int refresh_w(input int order, input int width);
        return 2 * width * order * (order + 1) / 2;
    endfunction

    // Stage k consumes 3*(k+1)*width bits; stages are packed back to back.
    function automatic int stage_rand_off(input int k, input int width);
        return 3 * width * k * (k + 1) / 2;
    endfunction

endpackage

// File: rtl/tsm_and_stage.sv
// One absorption stage of the masked AND: grows the A/B/C accumulators from
// K+1 to K+2 shares by folding in share K+1 of a and b.
module tsm_and_stage #(
    parameter int K     = 0,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       valid_in,
    input  logic [(K+1)*WIDTH-1:0]     a_acc,
    input  logic [(K+1)*WIDTH-1:0]     b_acc,
    input  logic [(K+1)*WIDTH-1:0]     c_acc,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    input  logic [3*(K+1)*WIDTH-1:0]   rnd,
    output logic [(K+2)*WIDTH-1:0]     a_reg,
    output logic [(K+2)*WIDTH-1:0]     b_reg,
    output logic [(K+2)*WIDTH-1:0]     c_reg,
    output logic                       valid_reg
);

    localparam int SW = (K + 1) * WIDTH;

    logic [SW-1:0]              r, s, t;
    logic [WIDTH-1:0]           r_sum, s_sum, t_sum;
    logic [(K+2)*WIDTH-1:0]     a_next, b_next, c_next;

    assign r = rnd[0    +: SW];
    assign s = rnd[SW   +: SW];
    assign t = rnd[2*SW +: SW];

    // Every AND operand here is a register output or a primary input.
    always_comb begin
        a_next = '0;
        b_next = '0;
        c_next = '0;
        r_sum  = '0;
        s_sum  = '0;
        t_sum  = '0;
        for (int j = 0; j <= K; j++) begin
            c_next[j*WIDTH +: WIDTH] = c_acc[j*WIDTH +: WIDTH]
                                     ^ (a_acc[j*WIDTH +: WIDTH] & y)
                                     ^ (b_acc[j*WIDTH +: WIDTH] & x)
                                     ^ r[j*WIDTH +: WIDTH];
            a_next[j*WIDTH +: WIDTH] = a_acc[j*WIDTH +: WIDTH] ^ s[j*WIDTH +: WIDTH];
            b_next[j*WIDTH +: WIDTH] = b_acc[j*WIDTH +: WIDTH] ^ t[j*WIDTH +: WIDTH];
            r_sum = r_sum ^ r[j*WIDTH +: WIDTH];
            s_sum = s_sum ^ s[j*WIDTH +: WIDTH];
            t_sum = t_sum ^ t[j*WIDTH +: WIDTH];
        end
        c_next[K*WIDTH +: WIDTH]     = c_next[K*WIDTH +: WIDTH] ^ (x & y);
        a_next[K*WIDTH +: WIDTH]     = a_next[K*WIDTH +: WIDTH] ^ x;
        b_next[K*WIDTH +: WIDTH]     = b_next[K*WIDTH +: WIDTH] ^ y;
        c_next[(K+1)*WIDTH +: WIDTH] = r_sum;
        a_next[(K+1)*WIDTH +: WIDTH] = s_sum;
        b_next[(K+1)*WIDTH +: WIDTH] = t_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            valid_reg <= 1'b0;
        end else if (en) begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            c_reg     <= c_next;
            valid_reg <= valid_in;
        end
    end

endmodule

// File: rtl/tsm_and_pipe.sv
// ORDER-stage masked AND pipeline producing shares of a&b plus refreshed a, b.
// Optional input share refresh is enabled with macro TSM_INPUT_REFRESH_EN.
module tsm_and_pipe
    import tsm_pkg::*;
#(
    parameter int ORDER = 2,
    parameter int WIDTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 in_valid,
    input  logic [(ORDER+1)*WIDTH-1:0]           a_i,
    input  logic [(ORDER+1)*WIDTH-1:0]           b_i,
    input  logic [rand_w(ORDER, WIDTH)-1:0]      rand_i,
`ifdef TSM_INPUT_REFRESH_EN
    input  logic [refresh_w(ORDER, WIDTH)-1:0]   rand_comp_i,
`endif
    output logic                                 out_valid,
    output logic [(ORDER+1)*WIDTH-1:0]           ab_o,
    output logic [(ORDER+1)*WIDTH-1:0]           a_o,
    output logic [(ORDER+1)*WIDTH-1:0]           b_o
);

    localparam int N = share_cnt(ORDER);

    logic [N*WIDTH-1:0] a_in, b_in;

`ifdef TSM_INPUT_REFRESH_EN
    // Pairwise refresh: each (i<j) pair gets one slice for a, then one for b.
    always_comb begin
        int p;
        a_in = a_i;
        b_in = b_i;
        p    = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                a_in[i*WIDTH +: WIDTH] = a_in[i*WIDTH +: WIDTH] ^ rand_comp_i[2*p*WIDTH +: WIDTH];
                a_in[j*WIDTH +: WIDTH] = a_in[j*WIDTH +: WIDTH] ^ rand_comp_i[2*p*WIDTH +: WIDTH];
                b_in[i*WIDTH +: WIDTH] = b_in[i*WIDTH +: WIDTH] ^ rand_comp_i[(2*p+1)*WIDTH +: WIDTH];
                b_in[j*WIDTH +: WIDTH] = b_in[j*WIDTH +: WIDTH] ^ rand_comp_i[(2*p+1)*WIDTH +: WIDTH];
                p = p + 1;
            end
        end
    end
`else
    assign a_in = a_i;
    assign b_in = b_i;
`endif

    genvar gi;
    for (gi = 0; gi < ORDER; gi++) begin : g_stage
        logic [(gi+1)*WIDTH-1:0] a_acc, b_acc, c_acc;
        logic [WIDTH-1:0]        x, y;
        logic                    v_in;
        logic [(gi+2)*WIDTH-1:0] a_reg, b_reg, c_reg;
        logic                    valid_reg;

        if (gi == 0) begin : g_head
            assign a_acc = a_in[0 +: WIDTH];
            assign b_acc = b_in[0 +: WIDTH];
            assign c_acc = a_in[0 +: WIDTH] & b_in[0 +: WIDTH];
            assign x     = a_in[WIDTH +: WIDTH];
            assign y     = b_in[WIDTH +: WIDTH];
            assign v_in  = in_valid;
        end else begin : g_body
            // Share gi+1 waits gi enabled cycles so it meets its operand here.
            logic [WIDTH-1:0] xd_reg [gi];
            logic [WIDTH-1:0] yd_reg [gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < gi; d++) begin
                        xd_reg[d] <= '0;
                        yd_reg[d] <= '0;
                    end
                end else if (en) begin
                    xd_reg[0] <= a_in[(gi+1)*WIDTH +: WIDTH];
                    yd_reg[0] <= b_in[(gi+1)*WIDTH +: WIDTH];
                    for (int d = 1; d < gi; d++) begin
                        xd_reg[d] <= xd_reg[d-1];
                        yd_reg[d] <= yd_reg[d-1];
                    end
                end
            end

            assign x     = xd_reg[gi-1];
            assign y     = yd_reg[gi-1];
            assign a_acc = g_stage[gi-1].a_reg;
            assign b_acc = g_stage[gi-1].b_reg;
            assign c_acc = g_stage[gi-1].c_reg;
            assign v_in  = g_stage[gi-1].valid_reg;
        end

        tsm_and_stage #(
            .K     (gi),
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .valid_in  (v_in),
            .a_acc     (a_acc),
            .b_acc     (b_acc),
            .c_acc     (c_acc),
            .x         (x),
            .y         (y),
            .rnd       (rand_i[stage_rand_off(gi, WIDTH) +: 3*(gi+1)*WIDTH]),
            .a_reg     (a_reg),
            .b_reg     (b_reg),
            .c_reg     (c_reg),
            .valid_reg (valid_reg)
        );
    end

    assign out_valid = g_stage[ORDER-1].valid_reg;
    assign ab_o      = g_stage[ORDER-1].c_reg;
    assign a_o       = g_stage[ORDER-1].a_reg;
    assign b_o       = g_stage[ORDER-1].b_reg;

endmodule

// File: tb/tb_tsm_and_pipe.sv
// Bench for tsm_and_pipe: four instances (D/W = 2/8, 3/4, 1/4, 2/1) checked by
// unmasking outputs against plain a&b arithmetic and a latency scoreboard.
module tb_tsm_and_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en;

    // DUT0: ORDER 2, WIDTH 8
    logic        v0_in, v0_out;
    logic [23:0] a0, b0, ab0, ao0, bo0;
    logic [71:0] r0;
    // DUT1: ORDER 3, WIDTH 4
    logic        v1_in, v1_out;
    logic [15:0] a1, b1, ab1, ao1, bo1;
    logic [71:0] r1;
    // DUT2: ORDER 1, WIDTH 4
    logic        v2_in, v2_out;
    logic [7:0]  a2, b2, ab2, ao2, bo2;
    logic [11:0] r2;
    // DUT3: ORDER 2, WIDTH 1
    logic        v3_in, v3_out;
    logic [2:0]  a3, b3, ab3, ao3, bo3;
    logic [8:0]  r3;

`ifdef TSM_INPUT_REFRESH_EN
    logic [47:0] rc0 = '1;
    logic [47:0] rc1 = '1;
    logic [7:0]  rc2 = '1;
    logic [5:0]  rc3 = '1;
`endif

    tsm_and_pipe #(.ORDER(2), .WIDTH(8)) u_d2w8 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(v0_in), .a_i(a0), .b_i(b0), .rand_i(r0),
`ifdef TSM_INPUT_REFRESH_EN
        .rand_comp_i(rc0),
`endif
        .out_valid(v0_out), .ab_o(ab0), .a_o(ao0), .b_o(bo0));

    tsm_and_pipe #(.ORDER(3), .WIDTH(4)) u_d3w4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(v1_in), .a_i(a1), .b_i(b1), .rand_i(r1),
`ifdef TSM_INPUT_REFRESH_EN
        .rand_comp_i(rc1),
`endif
        .out_valid(v1_out), .ab_o(ab1), .a_o(ao1), .b_o(bo1));

    tsm_and_pipe #(.ORDER(1), .WIDTH(4)) u_d1w4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(v2_in), .a_i(a2), .b_i(b2), .rand_i(r2),
`ifdef TSM_INPUT_REFRESH_EN
        .rand_comp_i(rc2),
`endif
        .out_valid(v2_out), .ab_o(ab2), .a_o(ao2), .b_o(bo2));

    tsm_and_pipe #(.ORDER(2), .WIDTH(1)) u_d2w1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(v3_in), .a_i(a3), .b_i(b3), .rand_i(r3),
`ifdef TSM_INPUT_REFRESH_EN
        .rand_comp_i(rc3),
`endif
        .out_valid(v3_out), .ab_o(ab3), .a_o(ao3), .b_o(bo3));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ab;
    } vec_t;

    typedef struct {
        int         e;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    vec_t        vecs [8];
    op_t         sb [$];
    op_t         op;
    int          en_edges, issued, cyc;
    logic        exp_v, pv;
    logic [7:0]  av, bv;
    logic [23:0] pab, pa, pb;
    logic [15:0] s_ab, s_a, s_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] unmask(input logic [31:0] v, input int n, input int w);
        logic [31:0] m, r;
        m = (32'd1 << w) - 32'd1;
        r = '0;
        for (int i = 0; i < n; i++) r = r ^ ((v >> (i * w)) & m);
        return r[7:0];
    endfunction

    function automatic logic [31:0] mk_shares(input logic [7:0] val, input int n, input int w);
        logic [31:0] m, v, acc, s;
        m   = (32'd1 << w) - 32'd1;
        acc = {24'h0, val} & m;
        v   = '0;
        for (int i = 1; i < n; i++) begin
            s   = $urandom & m;
            acc = acc ^ s;
            v   = v | (s << (i * w));
        end
        return v | acc;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'hF, 4'h9, 4'h9};
        vecs[1] = '{4'h0, 4'hF, 4'h0};
        vecs[2] = '{4'hA, 4'h5, 4'h0};
        vecs[3] = '{4'hC, 4'h6, 4'h4};
        vecs[4] = '{4'h7, 4'h7, 4'h7};
        vecs[5] = '{4'hF, 4'hF, 4'hF};
        vecs[6] = '{4'h3, 4'hE, 4'h2};
        vecs[7] = '{4'h8, 4'hC, 4'h8};

        rst_n = 1'b0; en = 1'b0;
        v0_in = 0; a0 = '0; b0 = '0; r0 = '0;
        v1_in = 0; a1 = '0; b1 = '0; r1 = '0;
        v2_in = 0; a2 = '0; b2 = '0; r2 = '0;
        v3_in = 0; a3 = '0; b3 = '0; r3 = '0;
        repeat (3) tick();

        check("rst_valid_d2w8", 32'(v0_out), 32'd0);
        check("rst_data_d2w8",  32'(|{ab0, ao0, bo0}), 32'd0);
        check("rst_valid_d3w4", 32'(v1_out), 32'd0);
        check("rst_data_d3w4",  32'(|{ab1, ao1, bo1}), 32'd0);
        check("rst_valid_d1w4", 32'(v2_out), 32'd0);
        check("rst_data_d1w4",  32'(|{ab2, ao2, bo2}), 32'd0);
        check("rst_valid_d2w1", 32'(v3_out), 32'd0);
        check("rst_data_d2w1",  32'(|{ab3, ao3, bo3}), 32'd0);

        rst_n = 1'b1; en = 1'b1;
        tick();

        // D=2, W=1, zero randomness: a shares 1,0,0 and b shares 0,1,0.
        a3 = 3'b001; b3 = 3'b010; r3 = '0; v3_in = 1'b1;
        tick();
        v3_in = 1'b0; a3 = '0; b3 = '0;
        check("d2w1_valid_cycle1", 32'(v3_out), 32'd0);
        tick();
        check("d2w1_valid_cycle2", 32'(v3_out), 32'd1);
        check("d2w1_ab", 32'(unmask(32'(ab3), 3, 1)), 32'd1);
        check("d2w1_a",  32'(unmask(32'(ao3), 3, 1)), 32'd1);
        check("d2w1_b",  32'(unmask(32'(bo3), 3, 1)), 32'd1);
        $display("txn d2w1 a=1 b=1 ab=%0h", unmask(32'(ab3), 3, 1));
        tick();
        check("d2w1_valid_after", 32'(v3_out), 32'd0);

        // D=1, W=4 table, back to back.
        for (int i = 0; i < 8; i++) begin
            a2 = 8'(mk_shares({4'h0, vecs[i].a}, 2, 4));
            b2 = 8'(mk_shares({4'h0, vecs[i].b}, 2, 4));
            r2 = 12'($urandom);
            v2_in = 1'b1;
            tick();
            v2_in = 1'b0;
            check("d1w4_valid", 32'(v2_out), 32'd1);
            check("d1w4_ab", 32'(unmask(32'(ab2), 2, 4)), 32'(vecs[i].ab));
            check("d1w4_a",  32'(unmask(32'(ao2), 2, 4)), 32'(vecs[i].a));
            check("d1w4_b",  32'(unmask(32'(bo2), 2, 4)), 32'(vecs[i].b));
            $display("txn d1w4 a=%h b=%h ab=%h", vecs[i].a, vecs[i].b, unmask(32'(ab2), 2, 4));
        end
        tick();
        check("d1w4_valid_idle", 32'(v2_out), 32'd0);

        // D=2, W=8 randomized back-to-back stream with random en stalls.
        en_edges = 0; issued = 0; cyc = 0;
        while ((issued < 1000 || sb.size() > 0) && cyc < 6000) begin
            en = ($urandom_range(0, 9) != 0);
            if (issued < 1000) begin
                av = (issued < 500) ? 8'hA5 : 8'($urandom);
                bv = (issued < 500) ? 8'h3C : 8'($urandom);
                a0 = 24'(mk_shares(av, 3, 8));
                b0 = 24'(mk_shares(bv, 3, 8));
                v0_in = 1'b1;
            end else begin
                v0_in = 1'b0;
            end
            r0 = {8'($urandom), 32'($urandom), 32'($urandom)};
            pv = v0_out; pab = ab0; pa = ao0; pb = bo0;
            tick();
            cyc++;
            if (en) begin
                en_edges++;
                if (v0_in) begin
                    sb.push_back('{en_edges, av, bv});
                    issued++;
                end
                exp_v = (sb.size() > 0) && (sb[0].e + 2 - 1 == en_edges);
                check("rnd_valid", 32'(v0_out), 32'(exp_v));
                if (exp_v) begin
                    op = sb.pop_front();
                    check("rnd_ab", 32'(unmask(32'(ab0), 3, 8)), 32'(op.a & op.b));
                    check("rnd_a",  32'(unmask(32'(ao0), 3, 8)), 32'(op.a));
                    check("rnd_b",  32'(unmask(32'(bo0), 3, 8)), 32'(op.b));
                    $display("txn d2w8 a=%h b=%h ab=%h", op.a, op.b, unmask(32'(ab0), 3, 8));
                end
            end else begin
                check("rnd_hold_valid", 32'(v0_out), 32'(pv));
                check("rnd_hold_ab", 32'(ab0), 32'(pab));
                check("rnd_hold_a",  32'(ao0), 32'(pa));
                check("rnd_hold_b",  32'(bo0), 32'(pb));
            end
        end
        check("rnd_drained", 32'(sb.size() + (1000 - issued)), 32'd0);
        en = 1'b1; v0_in = 1'b0;
        tick();

        // Reset with two operands in flight.
        a0 = 24'(mk_shares(8'h5A, 3, 8)); b0 = 24'(mk_shares(8'hFF, 3, 8));
        r0 = {8'($urandom), 32'($urandom), 32'($urandom)}; v0_in = 1'b1;
        tick();
        a0 = 24'(mk_shares(8'h33, 3, 8)); b0 = 24'(mk_shares(8'h0F, 3, 8));
        tick();
        v0_in = 1'b0;
        check("rst_mid_pre_valid", 32'(v0_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(v0_out), 32'd0);
        check("rst_mid_data",  32'(|{ab0, ao0, bo0}), 32'd0);
        $display("txn reset mid-flight valid=%0d", v0_out);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_stale", 32'(v0_out), 32'd0);
        end
        a0 = 24'(mk_shares(8'hC3, 3, 8)); b0 = 24'(mk_shares(8'h5E, 3, 8)); v0_in = 1'b1;
        tick();
        v0_in = 1'b0;
        check("rst_after_lat1", 32'(v0_out), 32'd0);
        tick();
        check("rst_after_lat2", 32'(v0_out), 32'd1);
        check("rst_after_ab", 32'(unmask(32'(ab0), 3, 8)), 32'h42);

        // D=3 stall of three cycles in the middle of the pipe.
        a1 = 16'(mk_shares(8'h0B, 4, 4)); b1 = 16'(mk_shares(8'h06, 4, 4));
        r1 = {8'($urandom), 32'($urandom), 32'($urandom)}; v1_in = 1'b1;
        tick();
        v1_in = 1'b0;
        r1 = {8'($urandom), 32'($urandom), 32'($urandom)};
        tick();
        check("stall_pre", 32'(v1_out), 32'd0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r1 = {8'($urandom), 32'($urandom), 32'($urandom)};
            tick();
            check("stall_frozen", 32'(v1_out), 32'd0);
        end
        en = 1'b1;
        r1 = {8'($urandom), 32'($urandom), 32'($urandom)};
        tick();
        check("stall_lat_valid", 32'(v1_out), 32'd1);
        check("stall_ab", 32'(unmask(32'(ab1), 4, 4)), 32'h2);
        check("stall_a",  32'(unmask(32'(ao1), 4, 4)), 32'hB);
        check("stall_b",  32'(unmask(32'(bo1), 4, 4)), 32'h6);
        $display("txn d3w4 a=b b=6 ab=%h", unmask(32'(ab1), 4, 4));
        tick();
        check("stall_valid_clear", 32'(v1_out), 32'd0);

        // Freeze while a result is on the outputs.
        a1 = 16'(mk_shares(8'h09, 4, 4)); b1 = 16'(mk_shares(8'h0D, 4, 4)); v1_in = 1'b1;
        tick();
        a1 = 16'(mk_shares(8'h07, 4, 4)); b1 = 16'(mk_shares(8'h0E, 4, 4));
        tick();
        v1_in = 1'b0;
        tick();
        check("hold_p_valid", 32'(v1_out), 32'd1);
        check("hold_p_ab", 32'(unmask(32'(ab1), 4, 4)), 32'h9);
        s_ab = ab1; s_a = ao1; s_b = bo1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = 16'($urandom); b1 = 16'($urandom); v1_in = 1'b1;
            r1 = {8'($urandom), 32'($urandom), 32'($urandom)};
            tick();
            check("hold_valid", 32'(v1_out), 32'd1);
            check("hold_ab", 32'(ab1), 32'(s_ab));
            check("hold_a",  32'(ao1), 32'(s_a));
            check("hold_b",  32'(bo1), 32'(s_b));
        end
        v1_in = 1'b0; en = 1'b1;
        tick();
        check("hold_q_valid", 32'(v1_out), 32'd1);
        check("hold_q_ab", 32'(unmask(32'(ab1), 4, 4)), 32'h6);
        $display("txn d3w4 a=7 b=e ab=%h", unmask(32'(ab1), 4, 4));
        tick();
        check("hold_valid_clear", 32'(v1_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
